// File: rtl/data_memory_sync.sv
// Single-port word memory with byte enables behind a fixed-latency request/response FSM.
// Handshake: a request is taken at a rising edge where req_i=1 and ready_o=1; exactly one rvalid_o cycle follows per accepted request.
module data_memory_sync #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [31:0]         addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                ready_o,
    output logic                rvalid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                err_o,
    output logic [1:0]          dbg_state_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam bit DIRECT = (LATENCY == 1);
    localparam logic [2:0] CNT_LOAD = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic              r_rvalid;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic              r_we;
    logic [BYTES-1:0]  r_be;
    logic [31:0]       r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_commit;
    logic              w_we;
    logic [BYTES-1:0]  w_be;
    logic [31:0]       w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [IDX_W-1:0]  w_idx;
    logic              w_err;

    assign ready_o  = !rst_i && (r_state != ST_WAIT);
    assign w_accept = req_i && ready_o;

    // With LATENCY=1 the accept edge is also the RESP-entry edge, so the live inputs are used.
    assign w_we    = DIRECT ? we_i    : r_we;
    assign w_be    = DIRECT ? be_i    : r_be;
    assign w_addr  = DIRECT ? addr_i  : r_addr;
    assign w_wdata = DIRECT ? wdata_i : r_wdata;

    assign w_commit = !rst_i && (DIRECT ? w_accept : (r_state == ST_WAIT && r_cnt == 3'd0));

    assign w_idx = w_addr[OFF_W+IDX_W-1:OFF_W];
    assign w_err = (w_addr[OFF_W-1:0] != '0) || (w_addr[31:OFF_W+IDX_W] != '0);

    // Memory is deliberately outside reset: contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (w_commit && w_we && !w_err) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 3'd0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_we     <= 1'b0;
            r_be     <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (w_accept) begin
                        r_we    <= we_i;
                        r_be    <= be_i;
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                        if (DIRECT) begin
                            r_state  <= ST_RESP;
                            r_rvalid <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_LOAD;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_state  <= ST_RESP;
                        r_rvalid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Response payload is captured only on RESP entry and held until the next one.
            if (w_commit) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_we) ? '0 : r_mem[w_idx];
            end
        end
    end

    assign rvalid_o    = r_rvalid;
    assign rdata_o     = r_rdata;
    assign err_o       = r_err;
    assign dbg_state_o = r_state;

endmodule

// File: doc/data_memory_sync.md
DATA_MEMORY_SYNC -- requirements
Module: data_memory_sync

Interface
REQ-001 Parameter DATA_W, 32, data word width in bits; SHALL be a multiple of 8, 16..128.
REQ-002 Parameter DEPTH, 256, number of words; SHALL be a power of two, 4..65536.
REQ-003 Parameter LATENCY, 2, cycles from accept to response; SHALL be in 1..7.
REQ-004 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 req_i  input  1  access request.
REQ-007 we_i  input  1  1 = write, 0 = read.
REQ-008 be_i  input  DATA_W/8  byte enables for writes; ignored on reads.
REQ-009 addr_i  input  32  byte address.
REQ-010 wdata_i  input  DATA_W  write data.
REQ-011 ready_o  output  1  request may be accepted this cycle.
REQ-012 rvalid_o  output  1  one-cycle response strobe for reads and writes.
REQ-013 rdata_o  output  DATA_W  read data, qualified by rvalid_o.
REQ-014 err_o  output  1  access error, qualified by rvalid_o.

Function
REQ-015 Word index SHALL be addr_i >> log2(DATA_W/8); offset SHALL be the low log2(DATA_W/8) address bits.
REQ-016 FSM SHALL have states IDLE, WAIT, RESP.
REQ-017 ready_o SHALL be 1 in IDLE and RESP, 0 in WAIT and while rst_i is 1.
REQ-018 Accept SHALL occur at a rising edge where req_i=1 and ready_o=1; we_i, be_i, addr_i, wdata_i SHALL be latched at that edge and later input changes ignored.
REQ-019 On accept: LATENCY=1 -> RESP; LATENCY>1 -> WAIT with counter loaded to LATENCY-2.
REQ-020 WAIT: counter SHALL decrement each cycle; at counter 0 the next state SHALL be RESP.
REQ-021 rvalid_o SHALL be 1 exactly in RESP cycles, i.e. the cycle following edge k+LATENCY-1 for an accept at edge k.
REQ-022 RESP: accept of a new request SHALL be allowed (back-to-back, one response per LATENCY cycles); no request -> IDLE.
REQ-023 Error SHALL be flagged when offset != 0 or word index >= DEPTH.
REQ-024 Memory update and read sample SHALL occur on the edge entering RESP; the write SHALL affect only bytes with be_i bit set; be_i=0 write SHALL change nothing and is not an error.
REQ-025 Erroring accesses SHALL not modify memory; response SHALL carry err_o=1, rdata_o=0.
REQ-026 Write response SHALL carry rdata_o=0, err_o=0 when legal.
REQ-027 Read response SHALL carry the word contents including all writes completed earlier; one outstanding access means no read/write hazard.
REQ-028 rdata_o and err_o SHALL hold their values until the next RESP entry.
REQ-029 Only one access SHALL be outstanding; req_i while ready_o=0 SHALL be ignored, not queued.

Reset
REQ-030 rst_i=1 at an edge SHALL force IDLE, counter 0, rvalid_o=0, err_o=0, rdata_o=0; rst_i has priority over all events.
REQ-031 Reset mid-operation SHALL abort the pending access: no write commit, no response.
REQ-032 Memory contents SHALL not be cleared by reset; unwritten words read undefined.

Verification
REQ-033 LATENCY=2: write addr 0x10, be=all ones, data 0xDEADBEEF; read 0x10 -> rvalid_o 2 cycles after each accept, rdata_o=0xDEADBEEF, err_o=0.
REQ-034 Partial write: word 0x11223344 at 0x20, then write be=0b0010 data 0x0000AA00 -> read returns 0x1122AA44.
REQ-035 Errors: read 0x22 (misaligned) and read DEPTH*4 -> err_o=1, rdata_o=0; write 0x22 -> memory at 0x20 unchanged.
REQ-036 Back-to-back: request held high for 4 accesses, LATENCY=1 -> accept every cycle, 4 consecutive rvalid_o pulses; LATENCY=3 -> one rvalid_o per 3 cycles, ready_o low in WAIT.
REQ-037 Reset in WAIT during write of 0x55555555 to 0x40 (previous value 0x0) -> no rvalid_o, ready_o=1 after release, read 0x40 returns 0x0.
